// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM state type and default geometry for the
// word-serial carry-lookahead adder cla_seq.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_SIZE  = 8;
    localparam int unsigned DEF_WORDS = 4;

endpackage

// File: rtl/cla_seq_cla.sv
// cla: purely combinational SIZE-bit carry-lookahead adder. Every carry is
// expanded directly from generate/propagate terms, so there is no ripple path.
module cla #(
    parameter int unsigned SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            cout
);

    logic [SIZE-1:0] g;
    logic [SIZE-1:0] p;
    logic [SIZE:0]   c;
    logic            acc;
    logic            prod;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = cin;
        for (int unsigned i = 0; i < SIZE; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int unsigned j = 0; j < i; j++) begin
                acc  = acc | (prod & g[i-1-j]);
                prod = prod & p[i-1-j];
            end
            acc    = acc | (prod & cin);
            c[i+1] = acc;
        end
    end

    assign s    = p ^ c[SIZE-1:0];
    assign cout = c[SIZE];

endmodule

// File: rtl/cla_seq.sv
// cla_seq: adds two SIZE*WORDS-bit operands one SIZE-bit word per cycle
// through a single shared cla, least significant word first, with a
// valid/ready handshake on each side.
// Optional build macro CLA_SEQ_OVF_EN adds the signed-overflow output ovf.
module cla_seq
    import cla_seq_pkg::*;
#(
    parameter int unsigned SIZE  = DEF_SIZE,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WORDS-1:0] a,
    input  logic [SIZE*WORDS-1:0] b,
    input  logic                  cin,
    output logic [SIZE*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int unsigned   W    = SIZE * WORDS;
    localparam int unsigned   IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            cout_q;
    logic [IW-1:0]   idx;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [SIZE-1:0] word_a;
    logic [SIZE-1:0] word_b;
    logic [SIZE-1:0] word_s;
    logic            word_c;
`ifdef CLA_SEQ_OVF_EN
    logic            ovf_q;
`endif

    assign word_a = a_q[idx*SIZE +: SIZE];
    assign word_b = b_q[idx*SIZE +: SIZE];

    cla #(
        .SIZE (SIZE)
    ) u_cla (
        .a    (word_a),
        .b    (word_b),
        .cin  (carry_q),
        .s    (word_s),
        .cout (word_c)
    );

    // Handshake FSM and word-serial datapath; outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx        <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx*SIZE +: SIZE] <= word_s;
                    carry_q                 <= word_c;
                    if (idx == LAST) begin
                        cout_q      <= word_c;
                        idx         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef CLA_SEQ_OVF_EN
                        // The final word's MSB is the result's sign bit
                        ovf_q <= (a_q[W-1] == b_q[W-1]) && (word_s[SIZE-1] != a_q[W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
